reg_file_rw: RTL and testbench

Parametrised integer register file for the RISC-V core: two combinational read ports, one synchronous write port, architectural x0 hardwired to zero, and an optional same-cycle write-to-read bypass. After reset, an internal sequencer initialises every register over NREGS cycles and holds `ready` low until it finishes. It sits between decode, which supplies the read indices, and writeback, which supplies the write.

---
 rtl/reg_file_rw.sv | 108 ++++++++++
 tb/tb_reg_file_rw.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/reg_file_rw.sv
// reg_file_rw: integer register file, two combinational read ports,
// one write port, x0 hardwired to zero, post-reset init sequencer.
module reg_file_rw #(
    parameter int XLEN       = 32,
    parameter int NREGS      = 32,
    parameter bit INIT_INDEX = 1'b1,
    parameter bit BYPASS     = 1'b1,
    localparam int AW        = $clog2(NREGS)
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [AW-1:0]   read_reg_num1,
    input  logic [AW-1:0]   read_reg_num2,
    output logic [XLEN-1:0] read_data1,
    output logic [XLEN-1:0] read_data2,
    input  logic            write_en,
    input  logic [AW-1:0]   write_reg_num,
    input  logic [XLEN-1:0] write_data,
    output logic            ready
);

    localparam logic [AW:0]   NR   = (AW+1)'(NREGS);
    localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t          state;
    logic [AW-1:0]   init_ptr;
    logic [XLEN-1:0] regs [NREGS];
    logic [XLEN-1:0] init_val;
    logic            accept;

    // Index 0 and indices past the last register are never backed by storage.
    function automatic logic valid_idx(input logic [AW-1:0] idx);
        return (idx != '0) && ({1'b0, idx} < NR);
    endfunction

    // Masked read with optional same-cycle forwarding of the accepted write.
    function automatic logic [XLEN-1:0] rd(input logic [AW-1:0] idx);
        logic [XLEN-1:0] v;
        v = '0;
        if (ready && valid_idx(idx)) begin
            if (BYPASS && accept && (write_reg_num == idx))
                v = write_data;
            else
                v = regs[idx];
        end
        return v;
    endfunction

    assign accept = ready && write_en && valid_idx(write_reg_num);

    // Init value: the register's own index, or zero; x0 is zero either way.
    always_comb begin
        init_val = '0;
        if (INIT_INDEX && (init_ptr != '0))
            init_val = XLEN'(init_ptr);
    end

    // Sequencer: walk every register once after reset, then run.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= INIT;
            init_ptr <= '0;
            ready    <= 1'b0;
        end else begin
            unique case (state)
                INIT: begin
                    if (init_ptr == LAST) begin
                        state    <= RUN;
                        init_ptr <= '0;
                        ready    <= 1'b1;
                    end else begin
                        init_ptr <= init_ptr + 1'b1;
                    end
                end
                RUN: begin
                    ready <= 1'b1;
                end
                default: begin
                    state    <= INIT;
                    init_ptr <= '0;
                    ready    <= 1'b0;
                end
            endcase
        end
    end

    // Storage: init writes during INIT, accepted writes in RUN, untouched in reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == INIT)
                regs[init_ptr] <= init_val;
            else if (accept)
                regs[write_reg_num] <= write_data;
        end
    end

    // Two independent combinational read ports.
    always_comb begin
        read_data1 = rd(read_reg_num1);
        read_data2 = rd(read_reg_num2);
    end

endmodule

// File: tb/tb_reg_file_rw.sv
// tb_reg_file_rw: directed checks of init, writes, x0, bypass,
// out-of-range indices and mid-run reset over four configurations.
module tb_reg_file_rw;

    logic        clock = 1'b0;
    logic        reset;
    logic [4:0]  r1, r2, wn;
    logic        we;
    logic [31:0] wd;

    logic [31:0] d1_a, d2_a, d1_b, d2_b, d1_c, d2_c, d1_d, d2_d;
    logic        rdy_a, rdy_b, rdy_c, rdy_d;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    // a: defaults
    reg_file_rw #(.XLEN(32), .NREGS(32), .INIT_INDEX(1'b1), .BYPASS(1'b1)) u_a (
        .clock(clock), .reset(reset),
        .read_reg_num1(r1), .read_reg_num2(r2),
        .read_data1(d1_a), .read_data2(d2_a),
        .write_en(we), .write_reg_num(wn), .write_data(wd),
        .ready(rdy_a));

    // b: no bypass
    reg_file_rw #(.XLEN(32), .NREGS(32), .INIT_INDEX(1'b1), .BYPASS(1'b0)) u_b (
        .clock(clock), .reset(reset),
        .read_reg_num1(r1), .read_reg_num2(r2),
        .read_data1(d1_b), .read_data2(d2_b),
        .write_en(we), .write_reg_num(wn), .write_data(wd),
        .ready(rdy_b));

    // c: 20 registers
    reg_file_rw #(.XLEN(32), .NREGS(20), .INIT_INDEX(1'b1), .BYPASS(1'b1)) u_c (
        .clock(clock), .reset(reset),
        .read_reg_num1(r1), .read_reg_num2(r2),
        .read_data1(d1_c), .read_data2(d2_c),
        .write_en(we), .write_reg_num(wn), .write_data(wd),
        .ready(rdy_c));

    // d: zero init
    reg_file_rw #(.XLEN(32), .NREGS(32), .INIT_INDEX(1'b0), .BYPASS(1'b1)) u_d (
        .clock(clock), .reset(reset),
        .read_reg_num1(r1), .read_reg_num2(r2),
        .read_data1(d1_d), .read_data2(d2_d),
        .write_en(we), .write_reg_num(wn), .write_data(wd),
        .ready(rdy_d));

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        we    = 1'b0;
        wn    = '0;
        wd    = '0;
        r1    = 5'd3;
        r2    = 5'd31;
        tick();
        check("rst_ready_a", {31'd0, rdy_a}, 32'd0);
        check("rst_ready_c", {31'd0, rdy_c}, 32'd0);
        check("rst_rd1_a", d1_a, 32'd0);
        check("rst_rd2_a", d2_a, 32'd0);

        // init; a write to x7 in the cycle ending at edge 3 must be dropped
        reset = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            we = (k == 3);
            wn = 5'd7;
            wd = 32'h1234;
            r1 = (k == 3) ? 5'd7 : 5'd3;
            tick();
            we = 1'b0;
            r1 = 5'd3;
            #1;
            check($sformatf("init_ready_a_%0d", k),
                  {31'd0, rdy_a}, {31'd0, k == 32});
            check($sformatf("init_ready_c_%0d", k),
                  {31'd0, rdy_c}, {31'd0, k >= 20});
            check($sformatf("init_rd1_a_%0d", k),
                  d1_a, (k == 32) ? 32'd3 : 32'd0);
        end

        r1 = 5'd3; r2 = 5'd31; #1;
        check("x3_a", d1_a, 32'h3);
        check("x31_a", d2_a, 32'h1F);
        check("x3_d", d1_d, 32'h0);
        check("x31_d", d2_d, 32'h0);
        r1 = 5'd0; r2 = 5'd7; #1;
        check("x0_a", d1_a, 32'h0);
        check("x7_init_drop_a", d2_a, 32'h7);
        r1 = 5'd19; r2 = 5'd25; #1;
        check("x19_c", d1_c, 32'h13);
        check("x25_c", d2_c, 32'h0);

        // write x5, observe bypass vs. stored path
        we = 1'b1; wn = 5'd5; wd = 32'hDEADBEEF; r1 = 5'd5; r2 = 5'd5; #1;
        check("byp_x5_a", d1_a, 32'hDEADBEEF);
        check("byp_x5_b", d1_b, 32'h5);
        check("byp_x5_d", d2_d, 32'hDEADBEEF);
        tick();
        we = 1'b0; #1;
        check("post_x5_a", d1_a, 32'hDEADBEEF);
        check("post_x5_b", d1_b, 32'hDEADBEEF);
        check("post_x5_d", d2_d, 32'hDEADBEEF);

        // write to x0 is ignored
        we = 1'b1; wn = 5'd0; wd = 32'hFFFFFFFF; r1 = 5'd0; r2 = 5'd0; #1;
        check("w0_rd1_a", d1_a, 32'h0);
        check("w0_rd2_a", d2_a, 32'h0);
        check("w0_rd1_b", d1_b, 32'h0);
        tick();
        we = 1'b0; #1;
        check("w0_post_a", d1_a, 32'h0);
        check("w0_post_b", d2_b, 32'h0);

        // index 25: out of range for c, valid for a
        we = 1'b1; wn = 5'd25; wd = 32'h55; r1 = 5'd25; r2 = 5'd19; #1;
        check("oor_rd1_c", d1_c, 32'h0);
        check("oor_rd2_c", d2_c, 32'h13);
        check("x25_byp_a", d1_a, 32'h55);
        tick();
        we = 1'b0; #1;
        check("oor_post_c", d1_c, 32'h0);
        check("oor_x19_c", d2_c, 32'h13);
        check("x25_post_a", d1_a, 32'h55);
        r1 = 5'd5; r2 = 5'd6; #1;
        check("x5_c", d1_c, 32'hDEADBEEF);
        check("x6_c", d2_c, 32'h6);

        // write x9 then pulse reset: full reinit
        we = 1'b1; wn = 5'd9; wd = 32'hAA;
        tick();
        we = 1'b0; r1 = 5'd9; r2 = 5'd5; #1;
        check("x9_a", d1_a, 32'hAA);
        reset = 1'b1;
        tick();
        reset = 1'b0; #1;
        check("rst2_ready_a", {31'd0, rdy_a}, 32'd0);
        check("rst2_rd1_a", d1_a, 32'd0);
        for (int k = 1; k <= 32; k++) begin
            tick();
            check($sformatf("reinit_rd1_a_%0d", k),
                  d1_a, (k == 32) ? 32'h9 : 32'h0);
            check($sformatf("reinit_ready_a_%0d", k),
                  {31'd0, rdy_a}, {31'd0, k == 32});
        end
        check("reinit_x5_a", d2_a, 32'h5);
        check("reinit_x9_b", d1_b, 32'h9);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
